recorder: RTL and testbench

Capture-side counterpart of the sample player: stores a burst of samples arriving on the sample clock into on-chip memory, in order, then lets the bus side read them back by address on its own clock. The block is a single-word leaf intended to be instantiated once per 32-bit lane under a bus/CSR wrapper. It exports a done flag and a capture count to both clock domains so the wrapper can raise an interrupt and software can poll progress.

---
 rtl/recorder_pkg.sv | 24 ++
 rtl/recorder_gray_sync.sv | 32 +++
 rtl/recorder.sv | 73 +++++++
 tb/tb_recorder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// rtl/recorder_pkg.sv - shared constants and Gray-code helpers for the recorder
package recorder_pkg;

    localparam int MAX_W = 32;

    function automatic int depth_of(input int time_bits);
        return 1 << time_bits;
    endfunction

    // Callers zero-extend into MAX_W bits and cast the result back to their width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/recorder_gray_sync.sv
// rtl/recorder_gray_sync.sv - monotonic counter crossing via Gray register and 2-flop sync
module gray_sync
    import recorder_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         src_clk,
    input  logic [W-1:0] src_bin,
    input  logic         dst_clk,
    output logic [W-1:0] dst_bin
);

    localparam logic [W-1:0] INIT_GRAY = W'(bin2gray(MAX_W'(INIT)));

    // Power-up values match INIT so the destination agrees with the source before any reset.
    logic [W-1:0] src_gray = INIT_GRAY;
    logic [W-1:0] sync1    = INIT_GRAY;
    logic [W-1:0] sync2    = INIT_GRAY;

    always_ff @(posedge src_clk) begin
        src_gray <= W'(bin2gray(MAX_W'(src_bin)));
    end

    always_ff @(posedge dst_clk) begin
        sync1 <= src_gray;
        sync2 <= sync1;
    end

    assign dst_bin = W'(gray2bin(MAX_W'(sync2)));

endmodule

// File: rtl/recorder.sv
// rtl/recorder.sv - burst sample capture into dual-clock RAM with bus-side readback
module recorder
    import recorder_pkg::*;
#(
    parameter int timeBits = 10,
    parameter int width    = 32
) (
    input  logic                r_clk,
    input  logic                r_reset_n,
    input  logic [width-1:0]    r_in,
    input  logic                r_strobe,
    output logic                r_done,
    output logic [timeBits:0]   r_count,
    input  logic                b_clk,
    input  logic                b_read,
    input  logic [timeBits-1:0] b_addr,
    output logic [width-1:0]    b_readdata,
    output logic                b_readvalid,
    output logic                b_done,
    output logic [timeBits:0]   b_count
);

    localparam int                DEPTH    = depth_of(timeBits);
    localparam logic [timeBits:0] PTR_IDLE = (timeBits + 1)'(DEPTH);

    // Starting full keeps an unarmed block from ever writing memory.
    logic [timeBits:0] wr_ptr = PTR_IDLE;
    logic [width-1:0]  mem [DEPTH];
    logic [width-1:0]  readdata_q;
    logic              readvalid_q = 1'b0;
    logic              wr_en;

    assign r_done  = wr_ptr[timeBits];
    assign r_count = wr_ptr;
    assign wr_en   = r_reset_n && r_strobe && !wr_ptr[timeBits];

    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (wr_en) begin
            mem[wr_ptr[timeBits-1:0]] <= r_in;
        end
    end

    always_ff @(posedge b_clk) begin
        readvalid_q <= b_read;
        if (b_read) begin
            readdata_q <= mem[b_addr];
        end
    end

    assign b_readdata  = readdata_q;
    assign b_readvalid = readvalid_q;

    gray_sync #(
        .W    (timeBits + 1),
        .INIT (PTR_IDLE)
    ) u_count_sync (
        .src_clk (r_clk),
        .src_bin (wr_ptr),
        .dst_clk (b_clk),
        .dst_bin (b_count)
    );

    assign b_done = b_count[timeBits];

endmodule

// File: tb/tb_recorder.sv
// tb/tb_recorder.sv - directed table-driven bench for recorder
`timescale 1ns/100ps
module tb_recorder;

    localparam int TB = 4;
    localparam int W  = 32;

    logic          r_clk = 1'b0;
    logic          r_reset_n;
    logic [W-1:0]  r_in;
    logic          r_strobe;
    logic          r_done;
    logic [TB:0]   r_count;
    logic          b_clk = 1'b0;
    logic          b_read;
    logic [TB-1:0] b_addr;
    logic [W-1:0]  b_readdata;
    logic          b_readvalid;
    logic          b_done;
    logic [TB:0]   b_count;

    recorder #(.timeBits(TB), .width(W)) dut (
        .r_clk       (r_clk),
        .r_reset_n   (r_reset_n),
        .r_in        (r_in),
        .r_strobe    (r_strobe),
        .r_done      (r_done),
        .r_count     (r_count),
        .b_clk       (b_clk),
        .b_read      (b_read),
        .b_addr      (b_addr),
        .b_readdata  (b_readdata),
        .b_readvalid (b_readvalid),
        .b_done      (b_done),
        .b_count     (b_count)
    );

    always #5    r_clk = ~r_clk;
    always #13.5 b_clk = ~b_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        strobe;
        logic [31:0] data;
        logic [4:0]  exp_count;
        logic        exp_done;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } rd_t;

    vec_t vq[$];
    rd_t  rq[$];

    task automatic push(input logic rst_n, input logic strobe, input logic [31:0] data,
                        input int cnt, input logic done);
        vec_t v;
        v.rst_n = rst_n; v.strobe = strobe; v.data = data;
        v.exp_count = 5'(cnt); v.exp_done = done;
        vq.push_back(v);
    endtask

    task automatic push_rd(input int addr, input logic [31:0] exp);
        rd_t r;
        r.addr = 4'(addr); r.exp = exp;
        rq.push_back(r);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            @(negedge r_clk);
            r_reset_n = vq[i].rst_n;
            r_strobe  = vq[i].strobe;
            r_in      = vq[i].data;
            @(posedge r_clk);
            #1;
            check($sformatf("%s r_count[%0d]", tag, i), 32'(r_count), 32'(vq[i].exp_count));
            check($sformatf("%s r_done[%0d]", tag, i), 32'(r_done), 32'(vq[i].exp_done));
        end
        @(negedge r_clk);
        r_strobe = 1'b0;
        vq.delete();
    endtask

    // Reads are issued back-to-back; each result is checked right after the capturing edge.
    task automatic run_reads(input string tag);
        logic [31:0] last;
        last = 32'h0;
        foreach (rq[i]) begin
            @(negedge b_clk);
            b_read = 1'b1;
            b_addr = rq[i].addr;
            @(posedge b_clk);
            #1;
            check($sformatf("%s data@%0d", tag, rq[i].addr), b_readdata, rq[i].exp);
            check($sformatf("%s valid@%0d", tag, rq[i].addr), 32'(b_readvalid), 32'd1);
            last = rq[i].exp;
        end
        @(negedge b_clk);
        b_read = 1'b0;
        @(posedge b_clk);
        #1;
        check({tag, " valid drop"}, 32'(b_readvalid), 32'd0);
        check({tag, " data hold"}, b_readdata, last);
        rq.delete();
    endtask

    task automatic wait_bcount(input string name, input int exp, input int budget);
        int n;
        n = 0;
        while (32'(b_count) != exp && n < budget) begin
            @(posedge b_clk);
            #1;
            n++;
        end
        check(name, 32'(b_count), 32'(exp));
    endtask

    logic        mon_en = 1'b0;
    logic [TB:0] mon_prev;

    always @(posedge b_clk) begin
        #1;
        if (mon_en) begin
            check("async b_count monotonic", 32'(b_count >= mon_prev), 32'd1);
            check("async b_count<=r_count", 32'(b_count <= r_count), 32'd1);
            mon_prev = b_count;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_reset_n = 1'b1;
        r_strobe  = 1'b0;
        r_in      = '0;
        b_read    = 1'b0;
        b_addr    = '0;

        // Power-up: idle and full, nothing armed.
        #1;
        check("pwr r_count", 32'(r_count), 32'd16);
        check("pwr r_done", 32'(r_done), 32'd1);
        check("pwr b_done", 32'(b_done), 32'd1);
        check("pwr b_readvalid", 32'(b_readvalid), 32'd0);

        for (int i = 0; i < 20; i++) push(1'b1, 1'b1, 32'hDEAD_0000 + i, 16, 1'b1);
        run_vecs("unarmed");
        repeat (4) @(posedge b_clk);
        #1;
        check("unarmed b_count", 32'(b_count), 32'd16);
        check("unarmed b_done", 32'(b_done), 32'd1);

        // Full capture, strobe held through and past full.
        push(1'b0, 1'b1, 32'hBAD, 0, 1'b0);
        for (int i = 0; i < 16; i++) push(1'b1, 1'b1, 32'h100 + i, i + 1, i == 15);
        push(1'b1, 1'b1, 32'hFFFF, 16, 1'b1);
        push(1'b1, 1'b1, 32'hFFFE, 16, 1'b1);
        run_vecs("full");
        for (int i = 0; i < 16; i++) push_rd(i, 32'h100 + i);
        run_reads("full rd");
        wait_bcount("full b_count", 16, 6);
        check("full b_done", 32'(b_done), 32'd1);

        // Gapped strobes.
        push(1'b0, 1'b0, 32'h0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b1, 32'h200 + i, i + 1, 1'b0);
            if (i < 4) begin
                push(1'b1, 1'b0, 32'hEEEE, i + 1, 1'b0);
                push(1'b1, 1'b0, 32'hEEEE, i + 1, 1'b0);
            end
        end
        run_vecs("gap");
        wait_bcount("gap b_count", 5, 5);
        check("gap b_done", 32'(b_done), 32'd0);
        for (int i = 0; i < 5; i++) push_rd(i, 32'h200 + i);
        push_rd(5, 32'h105);
        push_rd(15, 32'h10F);
        run_reads("gap rd");

        // Reset mid-capture leaves stale data beyond the new cursor.
        push(1'b0, 1'b0, 32'h0, 0, 1'b0);
        for (int i = 0; i < 7; i++) push(1'b1, 1'b1, 32'h300 + i, i + 1, 1'b0);
        push(1'b0, 1'b1, 32'h5555, 0, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 32'hAA00 + i, i + 1, 1'b0);
        run_vecs("rearm");
        wait_bcount("rearm b_count", 3, 6);
        for (int i = 0; i < 3; i++) push_rd(i, 32'hAA00 + i);
        for (int i = 3; i < 7; i++) push_rd(i, 32'h300 + i);
        push_rd(7, 32'h107);
        run_reads("rearm rd");

        // Continuous capture observed from the asynchronous bus side.
        push(1'b0, 1'b0, 32'h0, 0, 1'b0);
        push(1'b0, 1'b0, 32'h0, 0, 1'b0);
        run_vecs("async rst");
        @(negedge r_clk);
        r_reset_n = 1'b0;
        wait_bcount("async b_count zero", 0, 8);
        mon_prev = b_count;
        mon_en   = 1'b1;
        for (int i = 0; i < 16; i++) push(1'b1, 1'b1, 32'h400 + i, i + 1, i == 15);
        run_vecs("async");
        wait_bcount("async b_count final", 16, 6);
        check("async b_done", 32'(b_done), 32'd1);
        @(negedge b_clk);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
